// File: rtl/muldiv_hilo_ctrl_pkg.sv
// muldiv_hilo_ctrl_pkg
//   Types and constants for the HI/LO multiply/divide controller:
//   - MD_* opcode encoding driven by the decoder into EX
//   - controller state encoding
//   - divider iteration count and counter width
//   - absIf(): conditional two's-complement magnitude used when latching
//     signed divide operands
package muldiv_hilo_ctrl_pkg;

  localparam int OP_W      = 3;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdState_t;

  // Magnitude of v when en is set and v is negative; v unchanged otherwise.
  // 0x80000000 maps to itself, which reads correctly as an unsigned 2^31.
  function automatic logic [31:0] absIf(input logic [31:0] v, input logic en);
    return (en && v[31]) ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// muldiv_hilo_ctrl_if
//   EX-stage <-> HI/LO controller signal bundle.
//   master (pipeline): drives start, op, src_a, src_b, flush;
//                      sees busy (stall), done (commit pulse), hi, lo.
//   slave (controller): the reverse.
interface muldiv_hilo_ctrl_if;
  import muldiv_hilo_ctrl_pkg::*;

  logic            start;
  logic [OP_W-1:0] op;
  logic [31:0]     src_a;
  logic [31:0]     src_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [31:0]     hi;
  logic [31:0]     lo;

  modport master (output start, op, src_a, src_b, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, src_a, src_b, flush,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_hilo_ctrl_div_iter_step.sv
// div_iter_step
//   One combinational restoring-divide step.
//   remIn   : partial remainder (always < divisor on entry)
//   quoIn   : dividend bits still to shift in (MSB first) with quotient
//             bits accumulating at the bottom
//   divisor : divisor magnitude
//   remOut  : next partial remainder
//   quoOut  : quoIn shifted left with the new quotient bit at bit 0
module div_iter_step (
  input  logic [31:0] remIn,
  input  logic [31:0] quoIn,
  input  logic [31:0] divisor,
  output logic [31:0] remOut,
  output logic [31:0] quoOut
);
  // Shifted remainder needs 33 bits; trial[32] is the borrow out.
  logic [32:0] shifted;
  logic [32:0] trial;

  assign shifted = {remIn, quoIn[31]};
  assign trial   = shifted - {1'b0, divisor};
  assign remOut  = trial[32] ? shifted[31:0] : trial[31:0];
  assign quoOut  = {quoIn[30:0], ~trial[32]};
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Owns HI/LO and sequences MULT, MULTU, DIV, DIVU, MTHI, MTLO from EX.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : muldiv_hilo_ctrl_if.slave (start, op, src_a, src_b, flush
//                in; busy, done, hi, lo out)
//   Parameter MUL_LAT (1..15): cycles spent in the MUL state.
//   Build option MD_DIV0_FAST_EN: when defined, a divide by zero skips the
//   iterations and commits hi = src_a, lo = 0xFFFFFFFF on the next cycle.
//   When undefined it runs full length and leaves HI/LO untouched.
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  muldiv_hilo_ctrl_if.slave bus
);

  mdState_t         stateReg, stateNext;
  mdOp_t            opIn;
  logic [CNT_W-1:0] cntReg;
  logic [31:0]      opAReg;   // multiplicand, or dividend/quotient shifter
  logic [31:0]      opBReg;   // multiplier, or divisor magnitude
  logic [31:0]      remReg;
  logic [31:0]      hiReg, loReg;
  logic             mulSignedReg, quoNegReg, remNegReg, divZeroReg;

  logic             accept, isMul, isDiv, isSignedDiv, srcBZero, fastDiv0;
  logic [31:0]      stepRem, stepQuo, quoFinal, remFinal;
  logic [63:0]      product;

  assign opIn        = mdOp_t'(bus.op);
  assign accept      = bus.start & ~bus.flush;
  assign isMul       = (opIn == MD_MULT) || (opIn == MD_MULTU);
  assign isDiv       = (opIn == MD_DIV) || (opIn == MD_DIVU);
  assign isSignedDiv = (opIn == MD_DIV);
  assign srcBZero    = (bus.src_b == 32'd0);

`ifdef MD_DIV0_FAST_EN
  assign fastDiv0 = isDiv & srcBZero;
`else
  assign fastDiv0 = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= ST_IDLE;
    else     stateReg <= stateNext;
  end

  // ---------------- next state ----------------
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE: begin
        if (accept) begin
          if (isMul)      stateNext = ST_MUL;
          else if (isDiv) stateNext = fastDiv0 ? ST_DONE : ST_DIV;
        end
      end
      ST_MUL:  if (cntReg == '0) stateNext = ST_DONE;
      ST_DIV:  if (cntReg == '0) stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;   // start here is the same instruction leaving
      default: stateNext = ST_IDLE;
    endcase
    if (bus.flush) stateNext = ST_IDLE;
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (stateReg)
      ST_IDLE:         bus.busy = accept & (isMul | isDiv);
      ST_MUL, ST_DIV:  bus.busy = 1'b1;
      ST_DONE:         bus.done = ~bus.flush;
      default: ;
    endcase
  end

  assign bus.hi = hiReg;
  assign bus.lo = loReg;

  // ---------------- datapath ----------------
  div_iter_step uStep (
    .remIn   (remReg),
    .quoIn   (opAReg),
    .divisor (opBReg),
    .remOut  (stepRem),
    .quoOut  (stepQuo)
  );

  // Sign-extending only for MULT lets one 64x64 multiply (low half kept)
  // serve both signed and unsigned products.
  assign product  = {{32{mulSignedReg & opAReg[31]}}, opAReg}
                  * {{32{mulSignedReg & opBReg[31]}}, opBReg};
  assign quoFinal = quoNegReg ? 32'(-stepQuo) : stepQuo;
  assign remFinal = remNegReg ? 32'(-stepRem) : stepRem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntReg       <= '0;
      opAReg       <= '0;
      opBReg       <= '0;
      remReg       <= '0;
      hiReg        <= '0;
      loReg        <= '0;
      mulSignedReg <= 1'b0;
      quoNegReg    <= 1'b0;
      remNegReg    <= 1'b0;
      divZeroReg   <= 1'b0;
    end else if (!bus.flush) begin
      case (stateReg)
        ST_IDLE: begin
          if (bus.start) begin
            case (opIn)
              MD_MULT, MD_MULTU: begin
                opAReg       <= bus.src_a;
                opBReg       <= bus.src_b;
                mulSignedReg <= (opIn == MD_MULT);
                cntReg       <= CNT_W'(MUL_LAT - 1);
              end
              MD_DIV, MD_DIVU: begin
                opAReg     <= absIf(bus.src_a, isSignedDiv);
                opBReg     <= absIf(bus.src_b, isSignedDiv);
                remReg     <= '0;
                quoNegReg  <= isSignedDiv & (bus.src_a[31] ^ bus.src_b[31]);
                remNegReg  <= isSignedDiv & bus.src_a[31];
                divZeroReg <= srcBZero;
                cntReg     <= CNT_W'(DIV_ITERS - 1);
                if (fastDiv0) begin
                  hiReg <= bus.src_a;
                  loReg <= '1;
                end
              end
              MD_MTHI: hiReg <= bus.src_a;
              MD_MTLO: loReg <= bus.src_a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          cntReg <= cntReg - 1'b1;
          if (cntReg == '0) {hiReg, loReg} <= product;
        end
        ST_DIV: begin
          cntReg <= cntReg - 1'b1;
          remReg <= stepRem;
          opAReg <= stepQuo;
          // The last step's result is committed straight from the step logic.
          if (cntReg == '0 && !divZeroReg) begin
            hiReg <= remFinal;
            loReg <= quoFinal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;
  import muldiv_hilo_ctrl_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int MUL_BUSY = MUL_LAT + 1;
  localparam int DIV_BUSY = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_ctrl_if bus ();

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eHi;
    logic [31:0] eLo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busyCyc;
  } expRec_t;

  vec_t    vecs [0:9];
  expRec_t sbq [$];
  int      passCnt  = 0;
  int      totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Reference result {hi, lo} computed with wide integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = '0;
    case (op)
      MD_MULT:  p = 64'(sa * sbv);
      MD_MULTU: p = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        q = sa / sbv;
        r = sa % sbv;
        p = {r[31:0], q[31:0]};
      end
      MD_DIVU:  p = {a % b, a / b};
      default: ;
    endcase
    return p;
  endfunction

  // Issue one multi-cycle op, holding start as a stalled EX would, and
  // compare against the scoreboard entry when done arrives.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eHi, input logic [31:0] eLo, input int eBusy);
    expRec_t e;
    int busyCnt;
    int cyc;
    bit gotDone;
    sbq.push_back('{eHi, eLo, eBusy});
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    busyCnt = 0;
    gotDone = 1'b0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      #1;
      if (bus.done) begin
        gotDone = 1'b1;
        break;
      end
      if (bus.busy) busyCnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    e = sbq.pop_front();
    check("done_seen",    {31'd0, gotDone}, 32'd1);
    check("busy_in_done", {31'd0, bus.busy}, 32'd0);
    check("busy_cycles",  32'(busyCnt), 32'(e.busyCyc));
    check("done_cycle",   32'(cyc), 32'(e.busyCyc + 1));
    check("hi",           bus.hi, e.hi);
    check("lo",           bus.lo, e.lo);
    $display("op=%0d a=%08h b=%08h busy=%0d done@%0d hi=%08h lo=%08h",
             op, a, b, busyCnt, cyc, bus.hi, bus.lo);
  endtask

  task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MTHI; bus.src_a = h;
    @(negedge clk);
    bus.op = MD_MTLO; bus.src_a = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [63:0] m;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          sawDone;

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{MD_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
    vecs[4] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF};
    vecs[6] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{MD_DIV,   32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    vecs[8] = '{MD_DIV,   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2};
    vecs[9] = '{MD_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi",   bus.hi, 32'd0);
    check("rst_lo",   bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo,
            (vecs[i].op == MD_MULT || vecs[i].op == MD_MULTU) ? MUL_BUSY : DIV_BUSY);

    // Random ops against the reference model
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      m = model(rop, ra, rb);
      runOp(rop, ra, rb, m[63:32], m[31:0], (rop < 3'd2) ? MUL_BUSY : DIV_BUSY);
    end

    // MTHI then MTLO on consecutive cycles: no stall, no done
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'h1234_5678;
    #1 check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.op = MD_MTLO; bus.src_a = 32'h9;
    #1;
    check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    check("mthi_hi",   bus.hi, 32'h1234_5678);
    check("mt_done",   {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("mtlo_lo", bus.lo, 32'h9);
    check("mtlo_hi", bus.hi, 32'h1234_5678);
    $display("mthi/mtlo hi=%08h lo=%08h", bus.hi, bus.lo);

    // DIV flushed partway through: no done, HI/LO preserved
    writeHiLo(32'hCAFE_F00D, 32'h0BAD_BEEF);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    repeat (11) @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) sawDone = 1'b1;
      @(negedge clk); #1;
    end
    check("flush_no_done", {31'd0, sawDone}, 32'd0);
    check("flush_hi", bus.hi, 32'hCAFE_F00D);
    check("flush_lo", bus.lo, 32'h0BAD_BEEF);
    $display("div flushed hi=%08h lo=%08h", bus.hi, bus.lo);

    // flush together with start: op ignored
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'hDEAD_BEEF;
    #1 check("flush_start_mthi_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.op = MD_DIV; bus.src_a = 32'd5; bus.src_b = 32'd1;
    #1 check("flush_start_div_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check("flush_start_hi",   bus.hi, 32'hCAFE_F00D);
    check("flush_start_busy", {31'd0, bus.busy}, 32'd0);
    $display("flush+start hi=%08h lo=%08h", bus.hi, bus.lo);

    // Divide by zero
    writeHiLo(32'hA5A5_A5A5, 32'hA5A5_A5A5);
`ifdef MD_DIV0_FAST_EN
    runOp(MD_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1);
`else
    runOp(MD_DIVU, 32'h1234_5678, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, DIV_BUSY);
`endif

    // Reset asserted mid-multiply
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_hi",   bus.hi, 32'd0);
    check("midrst_lo",   bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("mid-op reset hi=%08h lo=%08h", bus.hi, bus.lo);
    runOp(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, MUL_BUSY);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
